// File: rtl/gpio_pkg.sv
// Shared register offsets and limits for the GPIO bank.
package gpio_pkg;
   localparam logic [2:0] GPIO_IN      = 3'd0;
   localparam logic [2:0] GPIO_OUT     = 3'd1;
   localparam logic [2:0] GPIO_OE      = 3'd2;
   localparam logic [2:0] GPIO_SET     = 3'd3;
   localparam logic [2:0] GPIO_CLR     = 3'd4;
   localparam logic [2:0] GPIO_STATUS  = 3'd5;
   localparam logic [2:0] GPIO_RISE_EN = 3'd6;
   localparam logic [2:0] GPIO_FALL_EN = 3'd7;

   localparam int unsigned GPIO_MAX_PINS = 32;
endpackage

// File: rtl/gpio_bank_if.sv
// CPU-side bus of the GPIO bank: select, word offset, strobes and data.
interface gpio_bank_if;
   logic        sel;
   logic [2:0]  addr;
   logic        re;
   logic [3:0]  we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, output addr, output re, output we, output wdata, input rdata);
   modport slave  (input sel, input addr, input re, input we, input wdata, output rdata);
endinterface

// File: rtl/gpio_pin_filter.sv
// One GPIO input: synchroniser, optional debounce (GPIO_DEBOUNCE_EN) and edge detector.
module gpio_pin_filter #(
   parameter int unsigned SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
   ,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   output logic filt,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES:0]   vld_q, vld_d;
   logic                   prev_q, prev_d;
   logic                   sync_in;

   assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   // Terminal count compares against DEBOUNCE_CYCLES-1 so the update lands on the reaching increment.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_in != filt_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = sync_in;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync_in;
`endif

   // vld_q marks when prev holds a sample taken after the synchroniser has refilled.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
      vld_d  = {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_d = filt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         vld_q  <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         vld_q  <= vld_d;
         prev_q <= prev_d;
      end
   end

   assign rise = vld_q[SYNC_STAGES] & filt & ~prev_q;
   assign fall = vld_q[SYNC_STAGES] & ~filt & prev_q;
endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: register file, bus logic and per-pin filters (GPIO_DEBOUNCE_EN optional).
module gpio_bank
   import gpio_pkg::*;
#(
   parameter int unsigned N_PINS          = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              reset,
   gpio_bank_if.slave        bus,
   output logic              irq,
   input  logic [N_PINS-1:0] pin_in,
   output logic [N_PINS-1:0] pin_out,
   output logic [N_PINS-1:0] pin_oe
);
   logic [N_PINS-1:0] out_q, out_d;
   logic [N_PINS-1:0] oe_q, oe_d;
   logic [N_PINS-1:0] status_q, status_d;
   logic [N_PINS-1:0] rise_en_q, rise_en_d;
   logic [N_PINS-1:0] fall_en_q, fall_en_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_q, irq_d;

   logic [N_PINS-1:0] filt_vec, rise_raw, fall_raw, edges, wval;
   logic [31:0]       rd_val;
   logic              wr_en, rd_en;
   logic              unused_wdata;

`ifndef GPIO_DEBOUNCE_EN
   localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

   for (genvar i = 0; i < N_PINS; i++) begin : g_pin
      gpio_pin_filter #(
         .SYNC_STAGES     (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
         ,
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
      ) u_filter (
         .clk    (clk),
         .reset  (reset),
         .pin_in (pin_in[i]),
         .filt   (filt_vec[i]),
         .rise   (rise_raw[i]),
         .fall   (fall_raw[i])
      );
   end

   assign wr_en        = bus.sel & (&bus.we);
   assign rd_en        = bus.sel & bus.re;
   assign wval         = bus.wdata[N_PINS-1:0];
   assign unused_wdata = ^bus.wdata;
   assign edges        = (rise_raw & rise_en_q) | (fall_raw & fall_en_q);

   always_comb begin
      out_d     = out_q;
      oe_d      = oe_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      // New edges are OR-ed in after the W1C mask so a same-cycle set survives the clear.
      status_d  = status_q | edges;
      if (wr_en) begin
         case (bus.addr)
            GPIO_OUT:     out_d     = wval;
            GPIO_OE:      oe_d      = wval;
            GPIO_SET:     out_d     = out_q | wval;
            GPIO_CLR:     out_d     = out_q & ~wval;
            GPIO_STATUS:  status_d  = (status_q & ~wval) | edges;
            GPIO_RISE_EN: rise_en_d = wval;
            GPIO_FALL_EN: fall_en_d = wval;
            default:      ;
         endcase
      end

      rd_val = '0;
      case (bus.addr)
         GPIO_IN:      rd_val[N_PINS-1:0] = filt_vec;
         GPIO_OUT:     rd_val[N_PINS-1:0] = out_q;
         GPIO_OE:      rd_val[N_PINS-1:0] = oe_q;
         GPIO_STATUS:  rd_val[N_PINS-1:0] = status_q;
         GPIO_RISE_EN: rd_val[N_PINS-1:0] = rise_en_q;
         GPIO_FALL_EN: rd_val[N_PINS-1:0] = fall_en_q;
         default:      rd_val = '0;
      endcase
      rdata_d = rd_en ? rd_val : rdata_q;
      irq_d   = |status_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q     <= '0;
         oe_q      <= '0;
         status_q  <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         oe_q      <= oe_d;
         status_q  <= status_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign irq       = irq_q;
   assign pin_out   = out_q;
   assign pin_oe    = oe_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (N_PINS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
module tb_gpio_bank;
   import gpio_pkg::*;

`ifdef GPIO_DEBOUNCE_EN
   localparam int FL = 8;
`else
   localparam int FL = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       irq;
   logic [3:0] pin_in;
   logic [3:0] pin_out;
   logic [3:0] pin_oe;
   logic [31:0] rd;
   int total = 0;
   int bad = 0;

   gpio_bank_if bus_if ();

   gpio_bank #(
      .N_PINS          (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_if.slave),
      .irq     (irq),
      .pin_in  (pin_in),
      .pin_out (pin_out),
      .pin_oe  (pin_oe)
   );

   always #5 clk = ~clk;

   // Bus tasks are entered at a negedge and return at the negedge after the active edge.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus_if.sel = 1'b1; bus_if.we = 4'hF; bus_if.addr = a; bus_if.wdata = d;
      @(negedge clk);
      bus_if.sel = 1'b0; bus_if.we = 4'h0; bus_if.wdata = '0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus_if.sel = 1'b1; bus_if.re = 1'b1; bus_if.addr = a;
      @(negedge clk);
      bus_if.sel = 1'b0; bus_if.re = 1'b0;
      d = bus_if.rdata;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] a;
         a = 3'(i);
         bus_read(a, rd);
         total++;
         if (rd !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", i, rd, 32'h0); end
      end
      total++;
      if (pin_oe !== 4'h0) begin bad++; $display("FAIL reset_oe got=%h exp=%h", pin_oe, 4'h0); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=%b", irq, 1'b0); end
   endtask

   task automatic test_set_clr();
      bus_write(GPIO_OE, 32'hF);
      bus_write(GPIO_OUT, 32'h5);
      total++;
      if (pin_out !== 4'h5) begin bad++; $display("FAIL out_write got=%h exp=%h", pin_out, 4'h5); end
      bus_write(GPIO_SET, 32'h2);
      total++;
      if (pin_out !== 4'h7) begin bad++; $display("FAIL out_set got=%h exp=%h", pin_out, 4'h7); end
      bus_write(GPIO_CLR, 32'h4);
      total++;
      if (pin_out !== 4'h3) begin bad++; $display("FAIL out_clr got=%h exp=%h", pin_out, 4'h3); end
      total++;
      if (pin_oe !== 4'hF) begin bad++; $display("FAIL oe_write got=%h exp=%h", pin_oe, 4'hF); end
      bus_read(GPIO_OUT, rd);
      total++;
      if (rd !== 32'h3) begin bad++; $display("FAIL read_out got=%h exp=%h", rd, 32'h3); end
      bus_read(GPIO_SET, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL read_set got=%h exp=%h", rd, 32'h0); end
   endtask

   task automatic test_rise();
      bus_write(GPIO_RISE_EN, 32'h1);
      pin_in[0] = 1'b1;
      repeat (3 + FL) @(negedge clk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=%b", irq, 1'b0); end
      @(negedge clk);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=%b", irq, 1'b1); end
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h1) begin bad++; $display("FAIL status_rise got=%h exp=%h", rd, 32'h1); end
      bus_write(GPIO_STATUS, 32'h1);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_lag got=%b exp=%b", irq, 1'b1); end
      @(negedge clk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_drop got=%b exp=%b", irq, 1'b0); end
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL status_w1c got=%h exp=%h", rd, 32'h0); end
   endtask

   task automatic test_collision();
      bus_write(GPIO_FALL_EN, 32'h2);
      pin_in[1] = 1'b1;
      repeat (6 + FL) @(negedge clk);
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL rise_disabled got=%h exp=%h", rd, 32'h0); end
      pin_in[1] = 1'b0;
      repeat (2 + FL) @(negedge clk);
      bus_write(GPIO_STATUS, 32'h2);
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h2) begin bad++; $display("FAIL collision got=%h exp=%h", rd, 32'h2); end
      bus_write(GPIO_STATUS, 32'h2);
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL w1c_after got=%h exp=%h", rd, 32'h0); end
   endtask

   task automatic test_bus_rules();
      bus_if.sel = 1'b1; bus_if.re = 1'b1; bus_if.we = 4'b0011;
      bus_if.addr = GPIO_OUT; bus_if.wdata = 32'h0;
      @(negedge clk);
      bus_if.sel = 1'b0; bus_if.re = 1'b0; bus_if.we = 4'h0;
      total++;
      if (bus_if.rdata !== 32'h3) begin bad++; $display("FAIL partial_read got=%h exp=%h", bus_if.rdata, 32'h3); end
      total++;
      if (pin_out !== 4'h3) begin bad++; $display("FAIL partial_we got=%h exp=%h", pin_out, 4'h3); end
      bus_write(GPIO_OUT, 32'hFFFF_FFFF);
      bus_read(GPIO_OUT, rd);
      total++;
      if (rd !== 32'hF) begin bad++; $display("FAIL upper_bits got=%h exp=%h", rd, 32'hF); end
      bus_if.sel = 1'b0; bus_if.we = 4'hF; bus_if.addr = GPIO_OUT; bus_if.wdata = 32'h0;
      @(negedge clk);
      bus_if.we = 4'h0;
      total++;
      if (pin_out !== 4'hF) begin bad++; $display("FAIL sel_low got=%h exp=%h", pin_out, 4'hF); end
      bus_if.sel = 1'b1; bus_if.re = 1'b1; bus_if.we = 4'hF;
      bus_if.addr = GPIO_OUT; bus_if.wdata = 32'h5;
      @(negedge clk);
      bus_if.sel = 1'b0; bus_if.re = 1'b0; bus_if.we = 4'h0;
      total++;
      if (bus_if.rdata !== 32'hF) begin bad++; $display("FAIL rw_old got=%h exp=%h", bus_if.rdata, 32'hF); end
      total++;
      if (pin_out !== 4'h5) begin bad++; $display("FAIL rw_write got=%h exp=%h", pin_out, 4'h5); end
      repeat (2) @(negedge clk);
      total++;
      if (bus_if.rdata !== 32'hF) begin bad++; $display("FAIL rdata_hold got=%h exp=%h", bus_if.rdata, 32'hF); end
   endtask

   task automatic test_loopback();
      pin_in = 4'b1010;
      repeat (3 + FL) @(negedge clk);
      bus_read(GPIO_IN, rd);
      total++;
      if (rd !== 32'hA) begin bad++; $display("FAIL loopback_in got=%h exp=%h", rd, 32'hA); end
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL enable_gate got=%h exp=%h", rd, 32'h0); end
   endtask

   task automatic test_reset_mid();
      bus_if.sel = 1'b1; bus_if.re = 1'b1; bus_if.addr = GPIO_OUT;
      reset = 1'b1;
      @(negedge clk);
      bus_if.sel = 1'b0; bus_if.re = 1'b0;
      reset = 1'b0;
      total++;
      if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", bus_if.rdata, 32'h0); end
      total++;
      if (pin_out !== 4'h0 || pin_oe !== 4'h0) begin
         bad++; $display("FAIL reset_pins got=%h/%h exp=0/0", pin_out, pin_oe);
      end
   endtask

`ifdef GPIO_DEBOUNCE_EN
   task automatic test_debounce();
      repeat (20) @(negedge clk);
      bus_write(GPIO_RISE_EN, 32'h4);
      bus_write(GPIO_FALL_EN, 32'h4);
      bus_write(GPIO_STATUS, 32'hF);
      pin_in[2] = 1'b1;
      repeat (5) @(negedge clk);
      pin_in[2] = 1'b0;
      repeat (20) @(negedge clk);
      bus_read(GPIO_IN, rd);
      total++;
      if (rd !== 32'hA) begin bad++; $display("FAIL glitch_in got=%h exp=%h", rd, 32'hA); end
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL glitch_status got=%h exp=%h", rd, 32'h0); end
      pin_in[2] = 1'b1;
      repeat (9) @(negedge clk);
      bus_read(GPIO_IN, rd);
      total++;
      if (rd !== 32'hA) begin bad++; $display("FAIL deb_early got=%h exp=%h", rd, 32'hA); end
      bus_read(GPIO_IN, rd);
      total++;
      if (rd !== 32'hE) begin bad++; $display("FAIL deb_change got=%h exp=%h", rd, 32'hE); end
      @(negedge clk);
      bus_read(GPIO_STATUS, rd);
      total++;
      if (rd !== 32'h4) begin bad++; $display("FAIL deb_status got=%h exp=%h", rd, 32'h4); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      pin_in = 4'h0;
      bus_if.sel = 1'b0; bus_if.re = 1'b0; bus_if.we = 4'h0;
      bus_if.addr = 3'd0; bus_if.wdata = 32'h0;
      @(negedge clk);
      test_reset();
      test_set_clr();
      test_rise();
      test_collision();
      test_bus_rules();
      test_loopback();
      test_reset_mid();
`ifdef GPIO_DEBOUNCE_EN
      test_debounce();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised memory-mapped GPIO peripheral. It replaces the fixed four-output, one-input GPIO logic and LED register currently hand-coded in the top level. It provides N bidirectional pins with:
- per-pin output enable
- atomic set/clear registers
- synchronised inputs
- sticky rising/falling-edge status with a level interrupt

It sits on the CPU bus beside the RAM and UART. The top level decodes `sel` and builds the tri-state pads from `pin_out` and `pin_oe`.

Parameters:
- N_PINS, 4, number of pins, legal range 1..32; register bits above N_PINS-1 read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser flops per pin, legal range 2..3.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before the filtered input changes; used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  block selected; decoded by the top level from the upper address bits.
- addr  in  3  word offset within the block.
- re  in  1  read strobe.
- we  in  4  byte write enables; a write occurs only when all four are set and sel=1.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- irq  out  1  level interrupt, registered.
- pin_in  in  N_PINS  raw asynchronous pad inputs.
- pin_out  out  N_PINS  output values.
- pin_oe  out  N_PINS  output enables; 1 = drive, 0 = high-Z.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high; clock port is `clk`, reset port is `reset`.
- Register map (word offsets):
  - 0 IN: read-only, synchronised (or filtered) input.
  - 1 OUT: read/write.
  - 2 OE: read/write.
  - 3 SET: write-only; 1 bits set the matching OUT bits; reads 0.
  - 4 CLR: write-only; 1 bits clear the matching OUT bits; reads 0.
  - 5 STATUS: edge flags; write-1-to-clear.
  - 6 RISE_EN: read/write.
  - 7 FALL_EN: read/write.
- Reset values: OUT, OE, STATUS, RISE_EN, FALL_EN, the synchroniser flops, `rdata` and `irq` are all 0. All pins are high-Z after reset.
- Read latency:
  - `rdata` is updated on the clock edge where sel & re = 1, and is valid in the cycle after the `re` tick (same timing as RAM).
  - `rdata` holds its value when there is no read.
  - A read with a partial `we` is treated as a read only.
- Writes:
  - Take effect on the clock edge of the write cycle; `pin_out`/`pin_oe` change in the next cycle.
  - A write with partial `we` is ignored.
  - A read and a write to the same register in the same cycle returns the old value.
- Input path: `pin_in`, then a chain of SYNC_STAGES flops, giving `sync_in`. IN reflects a pad change SYNC_STAGES cycles later.
- Edge detection:
  - prev = `sync_in` delayed by one flop.
  - rise = sync_in & ~prev & RISE_EN; fall = ~sync_in & prev & FALL_EN.
  - STATUS |= rise | fall.
  - The first valid sample after reset only loads prev; no edge is reported.
- W1C versus new edge in the same cycle: the set wins and the bit stays 1.
- Enable changes: clearing RISE_EN/FALL_EN does not clear existing STATUS bits.
- Interrupt: `irq` is registered as (|STATUS) and lags STATUS by one cycle.
- Looped-back pin: a pin with OE=1 still reads its pad value through IN.
- Reset mid-operation: all state returns to reset values on the next edge; a pending read returns 0.

Optional Feature:
GPIO_DEBOUNCE_EN:
- Defined: each pin has a counter of width $clog2(DEBOUNCE_CYCLES+1) between `sync_in` and the filtered value.
  - The counter resets to 0 whenever `sync_in` equals the filtered value.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES the filtered value takes `sync_in` and the counter returns to 0.
  - IN and edge detection use the filtered value.
  - Filtered value resets to 0.
- Undefined: the filtered value is `sync_in` directly and no counters are built.

Decomposition:
- Package gpio_pkg:
  - localparam register offsets GPIO_IN=0 … GPIO_FALL_EN=7.
  - GPIO_MAX_PINS=32.
- Sub-module gpio_pin_filter: one pin; contains the synchroniser, optional debounce and edge detector. Instantiated N_PINS times with a generate loop.
- The register file and bus logic stay in gpio_bank.

Test Plan:
1. Reset:
   - Assert reset for 2 cycles, then read offsets 0–7 → all read 0x0; pin_oe=0, irq=0.
2. Set/clear/read latency:
   - Write OE=0xF and OUT=0x5; write SET=0x2, then CLR=0x4.
   - pin_out goes 0x5, then 0x7, then 0x3.
   - A read of OUT returns 0x3 in the cycle after `re`.
3. Rising edge and W1C (N_PINS=4):
   - RISE_EN=0x1; drive pin_in[0] from 0 to 1.
   - STATUS=0x1 SYNC_STAGES+1 cycles later; irq one cycle after that.
   - Write STATUS=0x1 → STATUS=0, irq drops next cycle.
4. Collision:
   - Issue a W1C of STATUS bit 1 in the same cycle as a new fall on pin 1 (FALL_EN=0x2) → STATUS bit 1 remains 1.
5. Bus rules:
   - Write with we=4'b0011 → ignored.
   - Write OUT=0xFFFFFFFF with N_PINS=4 → reads back 0xF.
   - Writes with sel=0 → ignored.
6. Debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8):
   - A 5-cycle glitch on pin_in[2] → IN unchanged, no STATUS.
   - A level held for 12 cycles → IN bit 2 changes exactly 8 cycles after `sync_in` changes.
